sdff_sample_packer: RTL and testbench
=====================================

# sdff_sample_packer

Downstream consumer for the 2-bit synchronous-reset flop stage: captures the flop's Q output as a sample stream and packs consecutive samples into wider words. Words go out over a valid/ready interface through a 2-entry output FIFO. When the FIFO is full, completed words are dropped and counted rather than stalling, since the upstream flop has no backpressure. The block sits between the flop under test and the trace/export logic.

## Interface
- SAMPLE_W, 2, width of one input sample (matches flop Q width)
- SAMPLES, 4, samples packed per output word; power of two, 2..16
- DROP_W, 8, width of the saturating drop counter
- CLK  in  1  clock, all logic on rising edge
- SRST  in  1  reset, synchronous, active-low
- IN_DATA  in  SAMPLE_W  sample from upstream flop Q
- IN_VLD  in  1  sample qualifier; sample accepted on every CLK edge with IN_VLD=1
- FLUSH  in  1  emit partially filled word on this edge
- OUT_DATA  out  SAMPLE_W*SAMPLES  packed word at FIFO head
- OUT_CNT  out  clog2(SAMPLES)+1  number of valid samples in OUT_DATA (SAMPLES for full words)
- OUT_VLD  out  1  FIFO non-empty
- OUT_RDY  in  1  consumer accepts head word when OUT_VLD&OUT_RDY
- DROP_CNT  out  DROP_W  words lost to full FIFO, saturating

## Operation
- Reset (SRST=0 at edge): fill index=0, shift register=0, FIFO empty, DROP_CNT=0; OUT_VLD=0, OUT_DATA=0, OUT_CNT=0. Reset overrides all inputs, including mid-word and with OUT_VLD&OUT_RDY.
- Packing: k-th accepted sample of a word (k=0 first) stored at bits [k*SAMPLE_W +: SAMPLE_W]; unfilled positions are 0.
- Fill FSM, states COLLECT and COMMIT:
  - COLLECT: each accepted sample increments the index.
  - On sample SAMPLES-1, or on FLUSH with index>0, the word (with count) is committed to the FIFO in the same edge; FSM goes to COMMIT for one cycle only if the FIFO push and pop collide (see below), else stays in COLLECT.
  - Index resets to 0 on commit.
- FLUSH with IN_VLD on the same edge: the sample is included first, then the word is committed.
- FLUSH with index=0 and IN_VLD=0: no-op.
- Commit with FIFO full and no pop on the same edge: word discarded, DROP_CNT+1, saturating at all-ones. Commit with full FIFO and pop on the same edge: push succeeds, no drop.
- FIFO is 2-entry, first-in first-out. Pop on OUT_VLD&OUT_RDY. OUT_DATA/OUT_CNT hold stable while OUT_VLD=1 and OUT_RDY=0.
- Samples are never stalled; IN_VLD=1 samples are always absorbed into the shift register.

## Timing
- Latency: last sample of a word accepted at edge t gives OUT_VLD=1 and the word on OUT_DATA after edge t (registered, 1 cycle).
- Sustained rate: one word per SAMPLES cycles; FIFO never overflows if OUT_RDY is high at least 1 cycle in SAMPLES.
- DROP_CNT updates on the edge of the discarded commit.
- All outputs are registered; no combinational path from IN_* or FLUSH to outputs. OUT_VLD does not depend combinationally on OUT_RDY.

## Configuration
- PACKER_PARITY_EN defined: extra output OUT_PAR (1 bit) = XOR reduction of OUT_DATA, stored per FIFO entry, valid with OUT_VLD, reset 0.
- Not defined: OUT_PAR port and parity storage absent; all other behaviour identical.

## Structure
- Shared package sdff_pack_pkg: default SAMPLE_W/SAMPLES/DROP_W constants, fill-FSM state enum (COLLECT, COMMIT), packed entry typedef {data, cnt[, par]}.
- One sub-module: pack_fifo2 (2-entry FIFO with push/pop, full/empty, simultaneous push+pop when full).

## Test plan
- Reset then IN_VLD=1 with samples 01,10,11,00 → one cycle after 4th sample: OUT_VLD=1, OUT_DATA=8'h39, OUT_CNT=4.
- Samples 11,01 then FLUSH (IN_VLD=0) → OUT_DATA=8'h07, OUT_CNT=2; FLUSH with IN_VLD and sample 10 after 11 → OUT_DATA=8'h0B, OUT_CNT=2.
- OUT_RDY=0, stream 3 full words → first two held in order, third dropped, DROP_CNT=1; OUT_DATA unchanged while stalled.
- FIFO full, commit on same edge as pop → no drop, DROP_CNT stays 0, next two words come out in order.
- SRST=0 asserted after 2 samples, FIFO holding 1 word → next cycle OUT_VLD=0, DROP_CNT=0; next 4 samples form a clean word starting at bit 0.
- PACKER_PARITY_EN defined, word 8'h39 → OUT_PAR=0; word 8'h07 → OUT_PAR=1.

Source files
------------

// File: rtl/sdff_pack_pkg.sv
// Shared definitions for the sample packer: default geometry, fill-FSM
// encoding and the default FIFO entry layout.
// Optional feature macro: PACKER_PARITY_EN (adds per-entry parity bit).
package sdff_pack_pkg;

    localparam int DEF_SAMPLE_W = 2;
    localparam int DEF_SAMPLES  = 4;
    localparam int DEF_DROP_W   = 8;
    localparam int DEF_CNT_W    = $clog2(DEF_SAMPLES) + 1;

    // Fill FSM encoding; COMMIT marks a cycle after a push/pop collision.
    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        COMMIT  = 1'b1
    } fill_state_e;

    localparam logic [0:0] S_COLLECT = 1'b0;
    localparam logic [0:0] S_COMMIT  = 1'b1;

    // Default-geometry FIFO entry: packed word, valid sample count, parity.
    typedef struct packed {
        logic [DEF_SAMPLE_W*DEF_SAMPLES-1:0] data;
        logic [DEF_CNT_W-1:0]                cnt;
`ifdef PACKER_PARITY_EN
        logic                                par;
`endif
    } pack_entry_t;

endpackage

// File: rtl/pack_fifo2.sv
// Two-entry first-in first-out buffer. Entry 0 is always the head, so the
// head output comes straight from a flop. Push while full is accepted only
// when a pop happens on the same edge (caller guarantees this).
module pack_fifo2
    import sdff_pack_pkg::*;
#(
    parameter type entry_t = pack_entry_t
) (
    input  logic   CLK,
    input  logic   SRST,
    input  logic   push,
    input  logic   pop,
    input  entry_t din,
    output entry_t head,
    output logic   empty,
    output logic   full
);

    entry_t e0_q, e0_d, e1_q, e1_d;
    logic   v0_q, v0_d, v1_q, v1_d;
    logic   do_pop;

    // Next-state for the two slots; a pop shifts slot 1 into the head.
    always_comb begin
        e0_d   = e0_q;
        e1_d   = e1_q;
        v0_d   = v0_q;
        v1_d   = v1_q;
        do_pop = pop && v0_q;
        case ({push, do_pop})
            2'b10: begin
                if (!v0_q) begin
                    e0_d = din;
                    v0_d = 1'b1;
                end else if (!v1_q) begin
                    e1_d = din;
                    v1_d = 1'b1;
                end
            end
            2'b01: begin
                e0_d = e1_q;
                v0_d = v1_q;
                v1_d = 1'b0;
            end
            2'b11: begin
                if (v1_q) begin
                    e0_d = e1_q;
                    e1_d = din;
                end else begin
                    e0_d = din;
                end
            end
            default: ;
        endcase
    end

    // Slot registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!SRST) begin
            e0_q <= '0;
            e1_q <= '0;
            v0_q <= 1'b0;
            v1_q <= 1'b0;
        end else begin
            e0_q <= e0_d;
            e1_q <= e1_d;
            v0_q <= v0_d;
            v1_q <= v1_d;
        end
    end

    assign head  = e0_q;
    assign empty = !v0_q;
    assign full  = v1_q;

endmodule

// File: rtl/sdff_sample_packer.sv
// Packs the upstream flop's Q samples into SAMPLES-wide words and hands them
// to a 2-entry output FIFO. Upstream cannot be stalled, so commits that hit a
// full FIFO (with no pop on the same edge) are dropped and counted.
// Optional feature macro: PACKER_PARITY_EN (adds OUT_PAR, XOR of OUT_DATA).
module sdff_sample_packer
    import sdff_pack_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int SAMPLES  = DEF_SAMPLES,
    parameter int DROP_W   = DEF_DROP_W
) (
    input  logic                         CLK,
    input  logic                         SRST,
    input  logic [SAMPLE_W-1:0]          IN_DATA,
    input  logic                         IN_VLD,
    input  logic                         FLUSH,
    output logic [SAMPLE_W*SAMPLES-1:0]  OUT_DATA,
    output logic [$clog2(SAMPLES):0]     OUT_CNT,
    output logic                         OUT_VLD,
    input  logic                         OUT_RDY,
    output logic [DROP_W-1:0]            DROP_CNT
`ifdef PACKER_PARITY_EN
    ,
    output logic                         OUT_PAR
`endif
);

    localparam int DATA_W = SAMPLE_W * SAMPLES;
    localparam int IDX_W  = $clog2(SAMPLES);
    localparam int CNT_W  = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES - 1);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [CNT_W-1:0]  cnt;
`ifdef PACKER_PARITY_EN
        logic              par;
`endif
    } entry_t;

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [0:0]        state_q, state_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic [DATA_W-1:0] word_n;
    logic [CNT_W-1:0]  cnt_n;
    logic              commit;
    logic              drop;
    logic              collide;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    entry_t            push_entry;
    entry_t            head;

    // Absorb the incoming sample first, then decide whether this edge commits.
    always_comb begin
        word_n = shreg_q;
        if (IN_VLD) begin
            word_n[idx_q*SAMPLE_W +: SAMPLE_W] = IN_DATA;
        end
        cnt_n  = {1'b0, idx_q} + CNT_W'(IN_VLD);
        commit = (IN_VLD && (idx_q == LAST_IDX)) || (FLUSH && (cnt_n != '0));

        // A full FIFO still takes the word if the head leaves on this edge.
        fifo_pop  = !fifo_empty && OUT_RDY;
        fifo_push = commit && (!fifo_full || fifo_pop);
        drop      = commit && fifo_full && !fifo_pop;
        collide   = fifo_push && fifo_pop && fifo_full;

        // Restart at bit 0 with a cleared word so unfilled lanes read as 0.
        idx_d   = commit ? '0 : cnt_n[IDX_W-1:0];
        shreg_d = commit ? '0 : word_n;

        push_entry      = '0;
        push_entry.data = word_n;
        push_entry.cnt  = cnt_n;
`ifdef PACKER_PARITY_EN
        push_entry.par  = ^word_n;
`endif

        drop_d = (drop && (drop_q != '1)) ? drop_q + DROP_W'(1) : drop_q;
    end

    // Fill FSM: COMMIT lasts one cycle after a full-FIFO push/pop collision.
    always_comb begin
        state_d = S_COLLECT;
        case (state_q)
            S_COLLECT, S_COMMIT: state_d = collide ? S_COMMIT : S_COLLECT;
            default:             state_d = S_COLLECT;
        endcase
    end

    // Packer state registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!SRST) begin
            idx_q   <= '0;
            shreg_q <= '0;
            state_q <= S_COLLECT;
            drop_q  <= '0;
        end else begin
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            state_q <= state_d;
            drop_q  <= drop_d;
        end
    end

    pack_fifo2 #(
        .entry_t (entry_t)
    ) u_fifo (
        .CLK   (CLK),
        .SRST  (SRST),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (push_entry),
        .head  (head),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign OUT_DATA = head.data;
    assign OUT_CNT  = head.cnt;
    assign OUT_VLD  = !fifo_empty;
    assign DROP_CNT = drop_q;
`ifdef PACKER_PARITY_EN
    assign OUT_PAR  = head.par;
`endif

endmodule

// File: tb/tb_sdff_sample_packer.sv
// Scoreboard bench for sdff_sample_packer: a queue-based reference model
// predicts committed words, a negedge monitor compares the FIFO head.
module tb_sdff_sample_packer;

    localparam int SW = 2;
    localparam int NS = 4;
    localparam int DW = 8;
    localparam int WW = SW * NS;

    logic          CLK = 1'b0;
    logic          SRST;
    logic [SW-1:0] IN_DATA;
    logic          IN_VLD;
    logic          FLUSH;
    logic [WW-1:0] OUT_DATA;
    logic [2:0]    OUT_CNT;
    logic          OUT_VLD;
    logic          OUT_RDY;
    logic [DW-1:0] DROP_CNT;
`ifdef PACKER_PARITY_EN
    logic          OUT_PAR;
`endif

    sdff_sample_packer #(
        .SAMPLE_W (SW),
        .SAMPLES  (NS),
        .DROP_W   (DW)
    ) dut (
`ifdef PACKER_PARITY_EN
        .OUT_PAR  (OUT_PAR),
`endif
        .CLK      (CLK),
        .SRST     (SRST),
        .IN_DATA  (IN_DATA),
        .IN_VLD   (IN_VLD),
        .FLUSH    (FLUSH),
        .OUT_DATA (OUT_DATA),
        .OUT_CNT  (OUT_CNT),
        .OUT_VLD  (OUT_VLD),
        .OUT_RDY  (OUT_RDY),
        .DROP_CNT (DROP_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [WW-1:0] d;
        int            c;
    } exp_t;

    int            tests = 0;
    int            fails = 0;
    exp_t          sb[$];
    logic [SW-1:0] cur[$];
    int            occ = 0;
    int            drop_m = 0;
    bit            mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one call per clock edge, using the inputs seen at it.
    task automatic model_step();
        bit   pop;
        exp_t e;
        if (!SRST) begin
            sb.delete();
            cur.delete();
            occ    = 0;
            drop_m = 0;
            return;
        end
        pop = (occ > 0) && OUT_RDY;
        if (IN_VLD) cur.push_back(IN_DATA);
        if (cur.size() == NS || (FLUSH && cur.size() > 0)) begin
            e.d = '0;
            for (int k = 0; k < cur.size(); k++) e.d[k*SW +: SW] = cur[k];
            e.c = cur.size();
            cur.delete();
            if (occ < 2 || pop) begin
                sb.push_back(e);
                occ++;
            end else if (drop_m < (1 << DW) - 1) begin
                drop_m++;
            end
        end
        if (pop) occ--;
    endtask

    // Monitor: compare head against scoreboard, retire on handshake.
    always @(negedge CLK) begin
        if (mon_en) begin
            chk("out_vld", {31'b0, OUT_VLD}, {31'b0, occ > 0});
            chk("drop_cnt", 32'(DROP_CNT), 32'(drop_m));
            if (occ > 0) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_empty: got OUT_DATA %0h expected no word", OUT_DATA);
                end else begin
                    chk("out_data", 32'(OUT_DATA), 32'(sb[0].d));
                    chk("out_cnt", 32'(OUT_CNT), 32'(sb[0].c));
`ifdef PACKER_PARITY_EN
                    chk("out_par", {31'b0, OUT_PAR}, {31'b0, ^sb[0].d});
`endif
                    if (OUT_RDY && SRST) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic cyc(input logic srst, input logic vld, input logic [SW-1:0] d,
                       input logic fl, input logic rdy);
        SRST    = srst;
        IN_VLD  = vld;
        IN_DATA = d;
        FLUSH   = fl;
        OUT_RDY = rdy;
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic samp(input logic [SW-1:0] d, input logic rdy);
        cyc(1'b1, 1'b1, d, 1'b0, rdy);
    endtask

    task automatic idle(input logic rdy);
        cyc(1'b1, 1'b0, '0, 1'b0, rdy);
    endtask

    task automatic rst();
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        int rdy_pct;
        rst();
        mon_en = 1'b1;
        #2;
        chk("rst_vld", {31'b0, OUT_VLD}, 32'd0);
        chk("rst_data", 32'(OUT_DATA), 32'd0);
        chk("rst_cnt", 32'(OUT_CNT), 32'd0);
        chk("rst_drop", 32'(DROP_CNT), 32'd0);

        // Full word 01,10,11,00
        samp(2'b01, 0); samp(2'b10, 0); samp(2'b11, 0); samp(2'b00, 0);
        #2;
        chk("w39_vld", {31'b0, OUT_VLD}, 32'd1);
        chk("w39_data", 32'(OUT_DATA), 32'h39);
        chk("w39_cnt", 32'(OUT_CNT), 32'd4);
`ifdef PACKER_PARITY_EN
        chk("w39_par", {31'b0, OUT_PAR}, 32'd0);
`endif
        idle(1);

        // Flush without and with a same-edge sample
        samp(2'b11, 0); samp(2'b01, 0);
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b0);
        #2;
        chk("w07_data", 32'(OUT_DATA), 32'h07);
        chk("w07_cnt", 32'(OUT_CNT), 32'd2);
`ifdef PACKER_PARITY_EN
        chk("w07_par", {31'b0, OUT_PAR}, 32'd1);
`endif
        idle(1);
        samp(2'b11, 0);
        cyc(1'b1, 1'b1, 2'b10, 1'b1, 1'b0);
        #2;
        chk("w0b_data", 32'(OUT_DATA), 32'h0B);
        chk("w0b_cnt", 32'(OUT_CNT), 32'd2);
        cyc(1'b1, 1'b0, '0, 1'b1, 1'b1);   // flush on empty word: no-op
        idle(0);

        // Stall: three words, third dropped
        for (int i = 0; i < 4; i++) samp(2'b01, 0);
        for (int i = 0; i < 4; i++) samp(2'b10, 0);
        #2;
        chk("stall_head1", 32'(OUT_DATA), 32'h55);
        for (int i = 0; i < 4; i++) samp(2'b11, 0);
        #2;
        chk("stall_head2", 32'(OUT_DATA), 32'h55);
        chk("stall_drop", 32'(DROP_CNT), 32'd1);
        idle(1);
        #2;
        chk("stall_next", 32'(OUT_DATA), 32'hAA);
        idle(1);
        idle(0);

        // Full FIFO, commit with pop on the same edge
        rst();
        for (int i = 0; i < 4; i++) samp(2'b01, 0);
        for (int i = 0; i < 4; i++) samp(2'b10, 0);
        for (int i = 0; i < 3; i++) samp(2'b11, 0);
        samp(2'b11, 1);
        #2;
        chk("coll_drop", 32'(DROP_CNT), 32'd0);
        chk("coll_head", 32'(OUT_DATA), 32'hAA);
        idle(1);
        #2;
        chk("coll_tail", 32'(OUT_DATA), 32'hFF);
        idle(1);

        // Reset mid-word with a word queued
        for (int i = 0; i < 4; i++) samp(2'b01, 0);
        samp(2'b11, 0); samp(2'b11, 0);
        cyc(1'b0, 1'b1, 2'b10, 1'b1, 1'b1);
        #2;
        chk("mrst_vld", {31'b0, OUT_VLD}, 32'd0);
        chk("mrst_drop", 32'(DROP_CNT), 32'd0);
        samp(2'b10, 0); samp(2'b01, 0); samp(2'b00, 0); samp(2'b11, 0);
        #2;
        chk("mrst_word", 32'(OUT_DATA), 32'hC6);
        chk("mrst_cnt", 32'(OUT_CNT), 32'd4);

        // Randomized traffic with varying consumer throughput
        rdy_pct = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 200 == 0) begin
                case ($urandom_range(0, 2))
                    0: rdy_pct = 10;
                    1: rdy_pct = 50;
                    default: rdy_pct = 90;
                endcase
            end
            cyc($urandom_range(0, 199) != 0,
                $urandom_range(0, 3) != 0,
                SW'($urandom_range(0, 3)),
                $urandom_range(0, 7) == 0,
                $urandom_range(0, 99) < rdy_pct);
        end
        idle(1);
        idle(1);
        idle(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
